// File: rtl/alu_exec_stage_if.sv
// Operand/result handshake bundle between the issue logic, the execute stage and writeback.
// The master drives operations and accepts results; the slave is the execute stage.
interface alu_exec_stage_if #(
    parameter int NUM_SIZE = 32
);
    logic                inValid;
    logic                inReady;
    logic [NUM_SIZE-1:0] opA;
    logic [NUM_SIZE-1:0] opB;
    logic [2:0]          funct3;
    logic                altOp;
    logic                outValid;
    logic                outReady;
    logic [NUM_SIZE-1:0] result;
    logic                overflow;

    modport master (
        output inValid, opA, opB, funct3, altOp, outReady,
        input  inReady, outValid, result, overflow
    );

    modport slave (
        input  inValid, opA, opB, funct3, altOp, outReady,
        output inReady, outValid, result, overflow
    );
endinterface

// File: rtl/alu_exec_stage.sv
// RV32I integer execute stage: single-cycle add/sub/compare/logic and a
// 1-bit-per-cycle serial shifter, with a registered valid/ready result.

module alu_addsub #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         overflow
);
    logic [W-1:0] b_eff;
    logic [W:0]   full;

    // Subtraction is a + ~b + 1; overflow is judged on the negated operand.
    always_comb begin
        b_eff     = sub ? ~b : b;
        full      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
        sum       = full[W-1:0];
        carry_out = full[W];
        overflow  = (a[W-1] == b_eff[W-1]) & (sum[W-1] != a[W-1]);
    end
endmodule

module alu_exec_stage #(
    parameter int NUM_SIZE   = 32,
    parameter int SHAMT_SIZE = 5
) (
    input  logic                 clk,
    input  logic                 rstN,
    alu_exec_stage_if.slave      bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [NUM_SIZE-1:0]   result_q, result_d;
    logic                  overflow_q, overflow_d;
    logic [NUM_SIZE-1:0]   shreg_q, shreg_d;
    logic [SHAMT_SIZE-1:0] count_q, count_d;
    logic                  shl_q, shl_d;
    logic                  sra_q, sra_d;

    logic                  accept;
    logic                  is_shift;
    logic                  use_sub;
    logic [SHAMT_SIZE-1:0] shamt;
    logic [NUM_SIZE-1:0]   sum;
    logic                  carry_out;
    logic                  add_ovf;
    logic                  borrow;
    logic                  slt_bit;
    logic [NUM_SIZE-1:0]   alu_value;
    logic                  fill_bit;
    logic [NUM_SIZE-1:0]   shift_step;

    assign accept   = bus.inValid & (state_q == IDLE);
    assign is_shift = (bus.funct3 == 3'b001) | (bus.funct3 == 3'b101);
    assign shamt    = bus.opB[SHAMT_SIZE-1:0];
    assign use_sub  = ((bus.funct3 == 3'b000) & bus.altOp)
                    | (bus.funct3 == 3'b010) | (bus.funct3 == 3'b011);

    alu_addsub #(
        .W (NUM_SIZE)
    ) u_addsub (
        .a         (bus.opA),
        .b         (bus.opB),
        .sub       (use_sub),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (add_ovf)
    );

    // A subtraction with no carry out of the MSB means opA < opB unsigned.
    assign borrow  = ~carry_out;
    assign slt_bit = sum[NUM_SIZE-1] ^ add_ovf;

    always_comb begin
        alu_value = bus.opA;
        case (bus.funct3)
            3'b000:  alu_value = sum;
            3'b010:  alu_value = {{(NUM_SIZE-1){1'b0}}, slt_bit};
            3'b011:  alu_value = {{(NUM_SIZE-1){1'b0}}, borrow};
            3'b100:  alu_value = bus.opA ^ bus.opB;
            3'b110:  alu_value = bus.opA | bus.opB;
            3'b111:  alu_value = bus.opA & bus.opB;
            default: alu_value = bus.opA;
        endcase
    end

    assign fill_bit   = sra_q & shreg_q[NUM_SIZE-1];
    assign shift_step = shl_q ? {shreg_q[NUM_SIZE-2:0], 1'b0}
                              : {fill_bit, shreg_q[NUM_SIZE-1:1]};

    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        shreg_d    = shreg_q;
        count_d    = count_q;
        shl_d      = shl_q;
        sra_d      = sra_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (!is_shift) begin
                        result_d   = alu_value;
                        overflow_d = (bus.funct3 == 3'b000) & add_ovf;
                        state_d    = DONE;
                    end else if (shamt == '0) begin
                        result_d   = bus.opA;
                        overflow_d = 1'b0;
                        state_d    = DONE;
                    end else begin
                        shreg_d = bus.opA;
                        count_d = shamt;
                        shl_d   = (bus.funct3 == 3'b001);
                        sra_d   = (bus.funct3 == 3'b101) & bus.altOp;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shift_step;
                count_d = count_q - 1'b1;
                // The last step writes the result directly so no extra cycle is spent.
                if (count_q == {{(SHAMT_SIZE-1){1'b0}}, 1'b1}) begin
                    result_d   = shift_step;
                    overflow_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (bus.outReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            state_q    <= IDLE;
            result_q   <= '0;
            overflow_q <= 1'b0;
            shreg_q    <= '0;
            count_q    <= '0;
            shl_q      <= 1'b0;
            sra_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
            shreg_q    <= shreg_d;
            count_q    <= count_d;
            shl_q      <= shl_d;
            sra_q      <= sra_d;
        end
    end

    assign bus.inReady  = (state_q == IDLE);
    assign bus.outValid = (state_q == DONE);
    assign bus.result   = result_q;
    assign bus.overflow = overflow_q;
endmodule
